// File: rtl/pixel_span_iterator.sv
// Rasteriser stage-1 iterator: clips a bounding box to the screen and walks it row-major in
// spans of LANES pixels, emitting one registered beat per handshake with a lane mask and
// an incrementally maintained Z-buffer address.
module pixel_span_iterator #(
  parameter int unsigned COORD_W  = 16,
  parameter int unsigned SCREEN_W = 320,
  parameter int unsigned SCREEN_H = 240,
  parameter int unsigned LANES    = 4,
  parameter int unsigned ADDR_W   = 17
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [COORD_W-1:0] i_min_x,
  input  logic [COORD_W-1:0] i_max_x,
  input  logic [COORD_W-1:0] i_min_y,
  input  logic [COORD_W-1:0] i_max_y,
  output logic               o_busy,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic [LANES-1:0]   o_mask,
  output logic [ADDR_W-1:0]  o_zb_addr,
  output logic               o_done
);

  // Two guard bits so x+LANES never wraps before the signed compare against cx1.
  typedef logic signed [COORD_W+1:0] wide_t;
  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [COORD_W-1:0] XLim   = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] YLim   = COORD_W'(SCREEN_H - 1);
  localparam logic [ADDR_W-1:0]  Pitch  = ADDR_W'(SCREEN_W);
  localparam logic [ADDR_W-1:0]  AStep  = ADDR_W'(LANES);
  localparam logic [COORD_W-1:0] XStep  = COORD_W'(LANES);
  localparam logic [COORD_W-1:0] YStep  = COORD_W'(1);
  localparam wide_t              LanesW = wide_t'(LANES);

  function automatic wide_t widen(input logic [COORD_W-1:0] v);
    return wide_t'($signed(v));
  endfunction

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  cx0_q, cx0_d, cx1_q, cx1_d, cy1_q, cy1_d;
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, row_q, row_d;
  logic [LANES-1:0]    mask_q, mask_d;
  logic                valid_q, valid_d, done_q, done_d, busy_q, busy_d;

  logic [COORD_W-1:0]  clip_x0, clip_x1, clip_y0, clip_y1;
  logic                clip_empty;
  logic [ADDR_W-1:0]   start_addr;

  // Clip the requested box to the screen; the single constant multiply lives here.
  always_comb begin
    clip_x0    = i_min_x[COORD_W-1] ? '0 : i_min_x;
    clip_y0    = i_min_y[COORD_W-1] ? '0 : i_min_y;
    clip_x1    = ($signed(i_max_x) > $signed(XLim)) ? XLim : i_max_x;
    clip_y1    = ($signed(i_max_y) > $signed(YLim)) ? YLim : i_max_y;
    clip_empty = ($signed(clip_x0) > $signed(clip_x1)) || ($signed(clip_y0) > $signed(clip_y1));
    start_addr = ADDR_W'(clip_y0) * Pitch + ADDR_W'(clip_x0);
  end

  // Walk state machine: next state, next beat position and next address.
  always_comb begin
    state_d = state_q;
    cx0_d   = cx0_q;
    cx1_d   = cx1_q;
    cy1_d   = cy1_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    row_d   = row_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          cx0_d = clip_x0;
          cx1_d = clip_x1;
          cy1_d = clip_y1;
          if (clip_empty) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
            x_d     = clip_x0;
            y_d     = clip_y0;
            row_d   = start_addr;
            addr_d  = start_addr;
          end
        end
      end
      StRun: begin
        // Abort wins over a simultaneous handshake: the pending beat is dropped.
        if (i_abort) begin
          state_d = StDone;
        end else if (i_ready) begin
          if (widen(x_q) + LanesW <= widen(cx1_q)) begin
            x_d    = x_q + XStep;
            addr_d = addr_q + AStep;
          end else if ($signed(y_q) < $signed(cy1_q)) begin
            x_d    = cx0_q;
            y_d    = y_q + YStep;
            row_d  = row_q + Pitch;
            addr_d = row_q + Pitch;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    valid_d = (state_d == StRun);
    done_d  = (state_d == StDone);
    busy_d  = (state_d != StIdle);
  end

  // Lane mask for the next beat: lane k is live while x+k stays inside the clipped box.
  always_comb begin
    mask_d = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      mask_d[k] = (widen(x_d) + wide_t'(k) <= widen(cx1_d));
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cx0_q   <= '0;
      cx1_q   <= '0;
      cy1_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      row_q   <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cx0_q   <= cx0_d;
      cx1_q   <= cx1_d;
      cy1_q   <= cy1_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      row_q   <= row_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign o_busy    = busy_q;
  assign o_valid   = valid_q;
  assign o_done    = done_q;
  assign o_x       = x_q;
  assign o_y       = y_q;
  assign o_mask    = mask_q;
  assign o_zb_addr = addr_q;

endmodule
